// File: rtl/lift_lcd_status.sv
// lift_lcd_status: HD44780 16x2 driver for the lift status display.
// Runs power-up init, writes a fixed title, then rewrites the status line on demand.
module lift_lcd_status #(
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 12,
  parameter int HOLD_CYC   = 2,
  parameter int CMD_WAIT   = 2000,
  parameter int CLR_WAIT   = 82000,
  parameter int PWRUP_WAIT = 750000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [1:0] iMOV,
  input  logic       iUPD,
  output logic       oBUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int MAXW = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [127:0] TXT_TITLE = "SMARTLIFT       ";
  localparam logic [127:0] TXT_STOP  = "PARADO          ";
  localparam logic [127:0] TXT_UP    = "SUBINDO         ";
  localparam logic [127:0] TXT_DOWN  = "DESCENDO        ";
  localparam logic [127:0] TXT_BAD   = "----------------";

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_TITLE,
    S_IDLE,
    S_STATUS
  } top_t;

  typedef enum logic [1:0] {
    W_SETUP,
    W_EN,
    W_HOLD,
    W_WAIT
  } wr_t;

  top_t          state, state_n;
  wr_t           phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    idx, idx_n;
  logic [1:0]    code, code_n;
  logic [1:0]    shown, shown_n;
  logic          pend, pend_n;
  logic [7:0]    data_q;
  logic          rs_q, en_q;
  logic [8:0]    byte_n;
  logic          en_n;
  logic          is_clr;
  logic [4:0]    last_idx;

  // {rs, data} for a given position of the current sequence
  function automatic logic [8:0] byte_at(
    input top_t       st,
    input logic [4:0] ix,
    input logic [1:0] cd
  );
    logic [127:0] txt;
    logic [3:0]   k;
    logic [8:0]   b;
    b   = 9'h000;
    txt = TXT_TITLE;
    k   = 4'(ix - 5'd1);
    if (st == S_STATUS) begin
      unique case (cd)
        2'd0:    txt = TXT_STOP;
        2'd1:    txt = TXT_UP;
        2'd2:    txt = TXT_DOWN;
        default: txt = TXT_BAD;
      endcase
    end
    case (st)
      S_INIT: begin
        unique case (ix[1:0])
          2'd0:    b = 9'h038;
          2'd1:    b = 9'h00C;
          2'd2:    b = 9'h001;
          default: b = 9'h006;
        endcase
      end
      S_TITLE, S_STATUS: begin
        if (ix == 5'd0)
          b = {1'b0, (st == S_TITLE) ? 8'h80 : 8'hC0};
        else
          b = {1'b1, txt[{~k, 3'b000} +: 8]};
      end
      default: b = 9'h000;
    endcase
    return b;
  endfunction

  assign is_clr   = !rs_q && (data_q == 8'h01);
  assign last_idx = (state == S_INIT) ? 5'd3 : 5'd16;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= S_PWRUP;
      phase  <= W_SETUP;
      cnt    <= CW'(PWRUP_WAIT - 1);
      idx    <= '0;
      code   <= '0;
      shown  <= '0;
      pend   <= 1'b0;
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      code   <= code_n;
      shown  <= shown_n;
      pend   <= pend_n;
      rs_q   <= byte_n[8];
      data_q <= byte_n[7:0];
      en_q   <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    code_n  = code;
    shown_n = shown;
    pend_n  = pend;
    cnt_n   = (cnt != '0) ? cnt - CW'(1) : cnt;
    if (iUPD && state != S_IDLE)
      pend_n = 1'b1;
    unique case (state)
      S_PWRUP: begin
        if (cnt == '0) begin
          state_n = S_INIT;
          idx_n   = '0;
          phase_n = W_SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
        end
      end
      S_IDLE: begin
        // a pending request, a strobe and a code change all merge into one rewrite
        if (pend || iUPD || iMOV != shown) begin
          state_n = S_STATUS;
          idx_n   = '0;
          code_n  = iMOV;
          pend_n  = 1'b0;
          phase_n = W_SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
        end
      end
      default: begin
        if (cnt == '0) begin
          unique case (phase)
            W_SETUP: begin
              phase_n = W_EN;
              cnt_n   = CW'(EN_CYC - 1);
            end
            W_EN: begin
              phase_n = W_HOLD;
              cnt_n   = CW'(HOLD_CYC - 1);
            end
            W_HOLD: begin
              phase_n = W_WAIT;
              cnt_n   = is_clr ? CW'(CLR_WAIT - 1)
                               : CW'(CMD_WAIT - 1);
            end
            default: begin
              phase_n = W_SETUP;
              cnt_n   = CW'(SETUP_CYC - 1);
              if (idx != last_idx) begin
                idx_n = idx + 5'd1;
              end else begin
                idx_n = '0;
                case (state)
                  S_INIT: state_n = S_TITLE;
                  S_TITLE: begin
                    state_n = S_STATUS;
                    code_n  = iMOV;
                  end
                  default: begin
                    state_n = S_IDLE;
                    shown_n = code;
                  end
                endcase
              end
            end
          endcase
        end
      end
    endcase
    byte_n = byte_at(state_n, idx_n, code_n);
    en_n   = (phase_n == W_EN) &&
             (state_n == S_INIT || state_n == S_TITLE ||
              state_n == S_STATUS);
  end

  always_comb begin
    oBUSY    = (state != S_IDLE);
    LCD_DATA = data_q;
    LCD_RS   = rs_q;
    LCD_EN   = en_q;
    LCD_RW   = 1'b0;
  end

endmodule

// File: tb/tb_lift_lcd_status.sv
// tb_lift_lcd_status: captures LCD writes into a character-display model
// and checks init, status rewrites, request coalescing and async reset.
module tb_lift_lcd_status;

  localparam int SETUP = 1;
  localparam int ENC   = 2;
  localparam int HOLD  = 1;
  localparam int CMDW  = 4;
  localparam int CLRW  = 8;
  localparam int PWR   = 10;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic [1:0] iMOV = 2'd0;
  logic       iUPD = 1'b0;
  logic       oBUSY;
  logic [7:0] LCD_DATA;
  logic       LCD_EN, LCD_RS, LCD_RW;

  lift_lcd_status #(
    .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD),
    .CMD_WAIT(CMDW), .CLR_WAIT(CLRW), .PWRUP_WAIT(PWR)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iMOV(iMOV), .iUPD(iUPD),
    .oBUSY(oBUSY), .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;
  logic [1:0] mov_q = 2'd0;
  always @(posedge iCLK) mov_q <= iMOV;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [8:0] cap[$];
  int         cap_t[$];
  int         rel_cyc;
  int         busy_falls;
  int         en_run;
  bit         mon_on;
  bit         have_exp;
  logic [1:0] exp_code;
  logic       p_en, p_rs, p_busy;
  logic [7:0] p_data;
  logic [7:0] ddram[128];
  logic [6:0] addr;

  typedef struct {
    logic [1:0]   mov;
    logic         upd;
    logic [127:0] exp_txt;
    int           exp_n;
    int           exp_lat;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(string name, int idx,
                     logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h",
               name, idx, act, exp);
    end
  endtask

  function automatic logic [127:0] pad(string s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[8*(15-k) +: 8] = (k < s.len()) ? s[k] : 8'h20;
    return r;
  endfunction

  function automatic logic [127:0] status_txt(logic [1:0] c);
    case (c)
      2'd0:    return pad("PARADO");
      2'd1:    return pad("SUBINDO");
      2'd2:    return pad("DESCENDO");
      default: return pad("----------------");
    endcase
  endfunction

  function automatic logic [127:0] line_at(int base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = ddram[base+k];
    return r;
  endfunction

  // character-display model fed by every captured write
  task automatic emulate(logic rs, logic [7:0] d);
    if (!rs) begin
      if (d == 8'h01) begin
        for (int k = 0; k < 128; k++) ddram[k] = 8'h20;
        addr = 7'd0;
      end else if (d[7]) begin
        addr = d[6:0];
      end
    end else begin
      ddram[addr] = d;
      addr = addr + 7'd1;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge iCLK);
      if (iRST === 1'b0 && LCD_EN === 1'b1 && p_en !== 1'b1) begin
        cap.push_back({LCD_RS, LCD_DATA});
        cap_t.push_back(cyc);
        emulate(LCD_RS, LCD_DATA);
      end
      if (mon_on) begin
        chk("rw_low", cyc, 128'(LCD_RW), 128'(0));
        if (LCD_EN === 1'b1 || p_en === 1'b1)
          chk("bus_stable", cyc, 128'({LCD_RS, LCD_DATA}),
              128'({p_rs, p_data}));
        if (LCD_EN !== 1'b1 && p_en === 1'b1)
          chk("en_width", cyc, 128'(en_run), 128'(ENC));
        if (p_busy === 1'b0 && oBUSY === 1'b1) begin
          have_exp = 1'b1;
          exp_code = mov_q;
        end
        if (p_busy === 1'b1 && oBUSY === 1'b0 && have_exp)
          chk("line2_latched", cyc, line_at(64), status_txt(exp_code));
      end
      if (p_busy === 1'b1 && oBUSY === 1'b0) busy_falls++;
      en_run = (LCD_EN === 1'b1) ? en_run + 1 : 0;
      p_en   = LCD_EN;
      p_rs   = LCD_RS;
      p_data = LCD_DATA;
      p_busy = oBUSY;
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge iCLK);
      #1;
    end
  endtask

  task automatic wait_bytes(int n, int budget);
    int t;
    t = 0;
    while (cap.size() < n && t < budget) begin
      step();
      t++;
    end
    chk("bytes_reached", n, 128'(cap.size() >= n), 128'(1));
  endtask

  task automatic wait_idle(int budget);
    int t;
    t = 0;
    while (oBUSY !== 1'b0 && t < budget) begin
      step();
      t++;
    end
    chk("idle_reached", t, 128'(oBUSY), 128'(0));
  endtask

  task automatic expect_line(string nm, int base,
                             logic [7:0] cmd, logic [127:0] txt);
    chk({nm, "_len"}, base, 128'(cap.size() >= base + 17), 128'(1));
    if (cap.size() < base + 17) return;
    chk({nm, "_addr"}, base, 128'(cap[base]), 128'({1'b0, cmd}));
    for (int k = 0; k < 16; k++)
      chk({nm, "_char"}, k, 128'(cap[base+1+k]),
          128'({1'b1, txt[8*(15-k) +: 8]}));
  endtask

  task automatic check_init(logic [1:0] mov);
    logic [8:0]   e[$];
    logic [127:0] tt;
    int           w;
    e = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    tt = pad("SMARTLIFT");
    for (int k = 0; k < 16; k++) e.push_back({1'b1, tt[8*(15-k) +: 8]});
    e.push_back(9'h0C0);
    tt = status_txt(mov);
    for (int k = 0; k < 16; k++) e.push_back({1'b1, tt[8*(15-k) +: 8]});
    chk("init_len", 0, 128'(cap.size() >= 38), 128'(1));
    if (cap.size() < 38) return;
    chk("first_en_latency", 0, 128'(cap_t[0] - rel_cyc),
        128'(PWR + SETUP));
    for (int i = 0; i < 38; i++)
      chk("init_byte", i, 128'(cap[i]), 128'(e[i]));
    for (int i = 0; i < 37; i++) begin
      w = (e[i] == 9'h001) ? CLRW : CMDW;
      chk("init_gap", i, 128'(cap_t[i+1] - cap_t[i]),
          128'(SETUP + ENC + HOLD + w));
    end
    chk("disp_line1", 0, line_at(0), pad("SMARTLIFT"));
    chk("disp_line2", 0, line_at(64), status_txt(mov));
  endtask

  initial begin
    int base, f0, t0, t, quiet;
    vec_t v;
    mon_on = 1'b0;
    have_exp = 1'b0;
    busy_falls = 0;
    en_run = 0;
    addr = 7'd0;
    for (int k = 0; k < 128; k++) ddram[k] = 8'h20;
    fork
      monitor();
    join_none

    vecs[0] = '{2'd1, 1'b0, pad("SUBINDO"), 17, 2};
    vecs[1] = '{2'd2, 1'b0, pad("DESCENDO"), 17, 2};
    vecs[2] = '{2'd3, 1'b0, pad("----------------"), 17, 2};
    vecs[3] = '{2'd3, 1'b1, pad("----------------"), 17, 2};
    vecs[4] = '{2'd0, 1'b1, pad("PARADO"), 17, 2};
    vecs[5] = '{2'd0, 1'b1, pad("PARADO"), 17, 2};
    vecs[6] = '{2'd0, 1'b0, pad("PARADO"), 0, 0};

    #2 iRST = 1'b1;
    #1;
    chk("rst_data", 0, 128'(LCD_DATA), 128'(0));
    chk("rst_en", 0, 128'(LCD_EN), 128'(0));
    chk("rst_rs", 0, 128'(LCD_RS), 128'(0));
    chk("rst_rw", 0, 128'(LCD_RW), 128'(0));
    chk("rst_busy", 0, 128'(oBUSY), 128'(1));
    step(3);
    iRST = 1'b0;
    rel_cyc = cyc;
    busy_falls = 0;
    mon_on = 1'b1;
    wait_bytes(38, 2000);
    wait_idle(500);
    check_init(2'd0);
    chk("init_busy_falls", 0, 128'(busy_falls), 128'(1));

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      base = cap.size();
      f0 = busy_falls;
      t0 = cyc;
      iMOV = v.mov;
      iUPD = v.upd;
      step();
      iUPD = 1'b0;
      chk("busy_rise", i, 128'(oBUSY), 128'(v.exp_n != 0));
      if (v.exp_n != 0) begin
        wait_bytes(base + 17, 400);
        wait_idle(400);
      end
      step(30);
      chk("update_bytes", i, 128'(cap.size() - base), 128'(v.exp_n));
      chk("update_falls", i, 128'(busy_falls - f0), 128'(v.exp_n / 17));
      if (v.exp_n != 0 && cap.size() >= base + 17) begin
        chk("upd_latency", i, 128'(cap_t[base] - t0), 128'(v.exp_lat));
        expect_line("vec_line", base, 8'hC0, v.exp_txt);
        chk("vec_disp", i, line_at(64), v.exp_txt);
      end
    end

    // requests during a rewrite collapse into one follow-up
    base = cap.size();
    f0 = busy_falls;
    iMOV = 2'd1;
    step(20);
    iUPD = 1'b1; step(); iUPD = 1'b0;
    step(5);
    iMOV = 2'd2;
    iUPD = 1'b1; step(); iUPD = 1'b0;
    step(10);
    iUPD = 1'b1; step(); iUPD = 1'b0;
    chk("pend_still_busy", 0, 128'(oBUSY), 128'(1));
    wait_bytes(base + 34, 800);
    wait_idle(400);
    step(40);
    chk("pend_bytes", 0, 128'(cap.size() - base), 128'(34));
    chk("pend_falls", 0, 128'(busy_falls - f0), 128'(2));
    expect_line("pend_first", base, 8'hC0, pad("SUBINDO"));
    expect_line("pend_second", base + 17, 8'hC0, pad("DESCENDO"));

    // reset in the middle of the title line
    mon_on = 1'b0;
    have_exp = 1'b0;
    iRST = 1'b1;
    step(2);
    cap.delete();
    cap_t.delete();
    iRST = 1'b0;
    step();
    mon_on = 1'b1;
    t = 0;
    while (!(cap.size() >= 10 && LCD_EN === 1'b1) && t < 500) begin
      step();
      t++;
    end
    chk("mid_title_reached", t, 128'(LCD_EN), 128'(1));
    mon_on = 1'b0;
    iRST = 1'b1;
    #1;
    chk("rst_async_en", 0, 128'(LCD_EN), 128'(0));
    chk("rst_async_busy", 0, 128'(oBUSY), 128'(1));
    chk("rst_async_data", 0, 128'(LCD_DATA), 128'(0));
    step(2);
    cap.delete();
    cap_t.delete();
    iRST = 1'b0;
    rel_cyc = cyc;
    busy_falls = 0;
    step();
    mon_on = 1'b1;
    wait_bytes(38, 2000);
    wait_idle(500);
    if (cap.size() > 0)
      chk("restart_first", 0, 128'(cap[0]), 128'(9'h038));
    check_init(2'd2);
    chk("restart_falls", 0, 128'(busy_falls), 128'(1));

    // random traffic judged by the display model
    for (int r = 0; r < 40; r++) begin
      step($urandom_range(0, 150));
      if ($urandom_range(0, 1) == 1) iMOV = 2'($urandom_range(0, 3));
      iUPD = 1'($urandom_range(0, 1));
      step();
      iUPD = 1'b0;
    end
    t = 0;
    quiet = 0;
    while (quiet < 30 && t < 5000) begin
      step();
      t++;
      quiet = (oBUSY === 1'b0) ? quiet + 1 : 0;
    end
    chk("rand_settle", t, 128'(quiet >= 30), 128'(1));
    chk("rand_line1", 0, line_at(0), pad("SMARTLIFT"));
    chk("rand_line2", 0, line_at(64), status_txt(iMOV));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_lcd_status.md
# lift_lcd_status

Receiving end of the lift controller's LCD status interface: takes the 2-bit movement code and update strobe, and drives a 16x2 HD44780-compatible character LCD. The display shows a fixed title line and a status line. It runs the power-up/init sequence, performs paced 8-bit write cycles, and coalesces update requests that arrive while a write is in progress. It sits between the lift FSM and the board LCD pins, and replaces direct LCD driving from the controller.

## Interface
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises
- EN_CYC, 12: cycles EN is held high
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls
- CMD_WAIT, 2000: post-transfer wait in cycles (40 us at 50 MHz)
- CLR_WAIT, 82000: post-transfer wait after the clear command 0x01
- PWRUP_WAIT, 750000: wait after reset before the first command
- iCLK  in  1  system clock (CLOCK_50)
- iRST  in  1  reset; one clock; reset is asynchronous and active-high
- iMOV  in  2  movement code: 0 = stopped, 1 = up, 2 = down, 3 = invalid
- iUPD  in  1  single-cycle update request
- oBUSY  out  1  high while init runs or a line update is in progress
- LCD_DATA  out  8  LCD data bus
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = character
- LCD_RW  out  1  tied 0 (write only)

## Operation
- Top FSM states: PWRUP, INIT, TITLE, IDLE, STATUS.
- PWRUP: count PWRUP_WAIT cycles, then go to INIT.
- INIT: send commands 0x38, 0x0C, 0x01, 0x06 (RS=0), then go to TITLE.
- TITLE: send 0x80, then the 16 characters "SMARTLIFT" followed by 7 spaces (RS=1). Then go to STATUS with the code latched from iMOV, so the first status line reflects the current movement.
- STATUS: send 0xC0, then 16 characters, padded with spaces to 16:
  - code 0: "PARADO"
  - code 1: "SUBINDO"
  - code 2: "DESCENDO"
  - code 3: "----------------"
- At the end of STATUS: shown <= latched code, then go to IDLE.
- IDLE: oBUSY=0.
  - Enter STATUS when iUPD=1 or iMOV != shown; latch iMOV on the transition cycle.
  - If both occur in the same cycle, this counts as one update.
- pend flag:
  - Set when iUPD=1 while oBUSY=1 (any state).
  - Cleared when STATUS is entered from IDLE.
  - IDLE with pend=1 enters STATUS on the next cycle, even if iMOV == shown.
  - Any number of requests during a busy period collapses to exactly one follow-up update.
- iMOV changes during STATUS never alter characters already latched; the mismatch is picked up from IDLE afterwards.
- Write-cycle sub-FSM: SETUP -> EN_HI -> HOLD -> WAIT -> done.
  - LCD_RS and LCD_DATA are driven at SETUP entry and held constant through HOLD.
  - LCD_EN=1 only in EN_HI.
  - WAIT length is CLR_WAIT when the byte was command 0x01, otherwise CMD_WAIT.
- Counters: a single down-counter sized for max(PWRUP_WAIT, CLR_WAIT), loaded with param-1 and terminating at 0. Character index is 5 bits (0..16, where index 0 is the address command).

## Timing
- Reset values: LCD_DATA=0x00, LCD_EN=0, LCD_RS=0, LCD_RW=0, oBUSY=1, shown=0, pend=0, FSM=PWRUP.
- Asserting iRST mid-transfer forces LCD_EN=0 asynchronously and restarts from PWRUP; no partial sequence resumes.
- One transfer takes T = SETUP_CYC + EN_CYC + HOLD_CYC + wait cycles, with wait = CMD_WAIT or CLR_WAIT.
- Consecutive transfers are back to back: the next SETUP begins the cycle after WAIT ends.
- First LCD_EN rise occurs PWRUP_WAIT + SETUP_CYC cycles after reset release.
- A status update is 17 transfers. oBUSY rises the cycle after the triggering iUPD/mismatch and falls the cycle after the last WAIT ends.
- Latency from iUPD in IDLE to the first LCD_EN rise is 1 + SETUP_CYC cycles.
- LCD_RW is 0 in every cycle.

## Test plan
(Bench parameters: SETUP_CYC=1, EN_CYC=2, HOLD_CYC=1, CMD_WAIT=4, CLR_WAIT=8, PWRUP_WAIT=10.)
- Reset, iMOV=0 -> captured bytes are RS=0: 38,0C,01,06,80; then RS=1 "SMARTLIFT" + 7 spaces; RS=0 C0; RS=1 "PARADO" + 10 spaces.
  - Gap after the 01 transfer is 8 cycles; other gaps are 4 cycles.
  - oBUSY falls once, and LCD_EN pulses are exactly 2 cycles wide.
- In IDLE, set iMOV=1 -> after 1+1 cycles, EN rises with C0; then "SUBINDO" + 9 spaces. The same check with iMOV=2 gives "DESCENDO", and iMOV=3 gives 16 '-' characters.
- During a STATUS update, pulse iUPD three times and change iMOV 1->2 -> exactly one extra 17-byte update follows, showing "DESCENDO"; no third update.
- iUPD in IDLE with unchanged iMOV=0 -> one full update rewrites "PARADO"; oBUSY is high for 17 transfers.
- Assert iRST while LCD_EN=1 in the middle of the title line -> LCD_EN=0 in the same cycle; after release, the full sequence restarts from PWRUP with 38 as the first byte.
- Monitor throughout: LCD_DATA and LCD_RS are stable for every cycle where LCD_EN=1 and for 1 cycle before and after; LCD_RW never leaves 0.
